pipeline_writeback: RTL
=======================

PIPELINE_WRITEBACK -- requirements
Module: pipeline_writeback

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, datapath width; REG_COUNT, default 8, number of architectural registers.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 memory_done  input  1  memory-stage result valid this cycle.
REQ-005 memory_is_dependent  input  1  memory-stage instruction writes a register.
REQ-006 memory_result  input  DATA_W  value to write back.
REQ-007 memory_instr  input  16  instruction; rd = memory_instr[10:8].
REQ-008 issue_valid  input  1  decode issues an instruction this cycle.
REQ-009 issue_writes  input  1  issued instruction writes rd.
REQ-010 issue_rd  input  3  destination of issued instruction.
REQ-011 rs1_addr, rs2_addr  input  3 each  decode read addresses.
REQ-012 rs1_data, rs2_data  output  DATA_W each  read data.
REQ-013 rs1_busy, rs2_busy  output  1 each  operand has an outstanding write (decode must stall).
REQ-014 retire_count  output  16  instructions retired.
REQ-015 sb_error  output  1  sticky scoreboard over/underflow flag.

Function
REQ-016 Write enable wb_en SHALL be memory_done & memory_is_dependent & (rd != 0); on wb_en, regfile[rd] <= memory_result at the same posedge (zero-cycle stage latency).
REQ-017 Register 0 SHALL read 0 always and SHALL never be written.
REQ-018 Read ports SHALL be combinational from regfile, with the bypass behaviour of REQ-031/032.
REQ-019 Scoreboard: one 2-bit pending counter per register 1..7; issue_valid & issue_writes & issue_rd != 0 increments pending[issue_rd]; wb_en decrements pending[rd].
REQ-020 Simultaneous increment and decrement of the same register SHALL leave its counter unchanged.
REQ-021 Increment at count 3 SHALL hold at 3 and set sb_error; decrement at count 0 SHALL hold at 0 and set sb_error.
REQ-022 sb_error SHALL remain set until reset.
REQ-023 retire_count SHALL increment by 1 on each cycle with memory_done=1 (regardless of memory_is_dependent) and wrap 16'hFFFF -> 0.
REQ-024 rsN_busy SHALL be 0 when rsN_addr = 0.
REQ-025 Issue to a register in the same cycle as a read of it SHALL not affect that cycle's busy (counter is registered).

Reset
REQ-026 reset_n low SHALL immediately clear all registers, pending counters, retire_count and sb_error to 0.
REQ-027 Outputs during reset SHALL be: rsN_data 0, rsN_busy 0, retire_count 0, sb_error 0.
REQ-028 Reset asserted mid-operation SHALL discard any write whose edge coincides with reset low; the first write is accepted on the first posedge after reset_n rises.

Configuration
REQ-029 Macro WB_BYPASS_EN SHALL select same-cycle bypass.
REQ-030 Without WB_BYPASS_EN: rsN_busy = (pending[rsN_addr] != 0); rsN_data = stored regfile value.
REQ-031 With WB_BYPASS_EN: when wb_en and rd = rsN_addr != 0, rsN_data SHALL be memory_result.
REQ-032 With WB_BYPASS_EN: rsN_busy SHALL be 0 when pending[rsN_addr] = 1 and that write is completing this cycle; otherwise as REQ-030.

Structure
REQ-033 Shared package tsp16_pkg SHALL hold DATA_W, REG_COUNT, the rd field bit positions and the pending-counter typedef.
REQ-034 A sub-module wb_scoreboard SHALL implement the pending counters, saturation and sb_error; register file and retire counter stay in pipeline_writeback.

Verification
REQ-035 Reset, then write r3 = 16'h1234 (memory_done = dep = 1, instr[10:8] = 3) -> next cycle rs1_addr = 3 reads 16'h1234; retire_count = 1.
REQ-036 Write to r0 with 16'hFFFF -> rs1_addr = 0 reads 0, rs1_busy = 0, retire_count increments.
REQ-037 Issue r5 twice, then one writeback to r5 -> busy 1 after each step until the second writeback; same-cycle issue and writeback of r5 leaves count unchanged.
REQ-038 Four issues to r2 with no writeback -> pending saturates at 3, sb_error = 1; writeback with pending 0 on r4 -> sb_error = 1; both hold until reset_n = 0.
REQ-039 With WB_BYPASS_EN: pending[r6] = 1, wb of r6 = 16'hBEEF while rs2_addr = 6 -> same cycle rs2_data = 16'hBEEF, rs2_busy = 0; without the macro -> rs2_busy = 1 and old data.
REQ-040 Preload retire_count to 16'hFFFF via 65535 retirements, one more memory_done -> retire_count = 0; reset_n low mid-write -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tsp16_pkg.sv
// Shared definitions for the writeback stage: datapath defaults, rd field position
// and the pending-write counter type used by the scoreboard.
package tsp16_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_COUNT = 8;
    localparam int RADDR_W   = 3;
    localparam int RD_MSB    = 10;
    localparam int RD_LSB    = 8;

    typedef logic [1:0] pend_t;

    localparam pend_t PEND_MAX = 2'd3;
    localparam pend_t PEND_MIN = 2'd0;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register outstanding-write counters (2-bit, saturating) with a sticky
// over/underflow flag; register 0 has no counter and always reads as idle.
module wb_scoreboard
    import tsp16_pkg::pend_t, tsp16_pkg::RADDR_W, tsp16_pkg::PEND_MAX, tsp16_pkg::PEND_MIN;
#(
    parameter int REG_COUNT = tsp16_pkg::REG_COUNT
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               inc_en_i,
    input  logic [RADDR_W-1:0] inc_rd_i,
    input  logic               dec_en_i,
    input  logic [RADDR_W-1:0] dec_rd_i,
    input  logic [RADDR_W-1:0] rs1_addr_i,
    input  logic [RADDR_W-1:0] rs2_addr_i,
    output pend_t              rs1_pend_o,
    output pend_t              rs2_pend_o,
    output logic               sb_error_o
);

    pend_t pend_q [REG_COUNT];
    pend_t pend_d [REG_COUNT];
    logic  err_q;
    logic  err_d;

    always_comb begin
        logic inc;
        logic dec;
        err_d = err_q;
        for (int r = 0; r < REG_COUNT; r++) begin
            pend_d[r] = pend_q[r];
        end
        for (int r = 1; r < REG_COUNT; r++) begin
            inc = inc_en_i && (inc_rd_i == RADDR_W'(r));
            dec = dec_en_i && (dec_rd_i == RADDR_W'(r));
            // A matched issue and retire cancel, even at the saturation limits.
            if (inc && !dec) begin
                if (pend_q[r] == PEND_MAX) begin
                    err_d = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] + 2'd1;
                end
            end else if (dec && !inc) begin
                if (pend_q[r] == PEND_MIN) begin
                    err_d = 1'b1;
                end else begin
                    pend_d[r] = pend_q[r] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                pend_q[r] <= PEND_MIN;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                pend_q[r] <= pend_d[r];
            end
            err_q <= err_d;
        end
    end

    assign rs1_pend_o = pend_q[rs1_addr_i];
    assign rs2_pend_o = pend_q[rs2_addr_i];
    assign sb_error_o = err_q;

endmodule

// File: rtl/pipeline_writeback.sv
// Writeback stage: register file, retire counter and scoreboard-driven busy flags.
// Define WB_BYPASS_EN to forward the completing write to the read ports in the same cycle.
module pipeline_writeback
    import tsp16_pkg::pend_t, tsp16_pkg::RADDR_W, tsp16_pkg::RD_MSB, tsp16_pkg::RD_LSB;
#(
    parameter int DATA_W    = tsp16_pkg::DATA_W,
    parameter int REG_COUNT = tsp16_pkg::REG_COUNT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               memory_done,
    input  logic               memory_is_dependent,
    input  logic [DATA_W-1:0]  memory_result,
    input  logic [15:0]        memory_instr,
    input  logic               issue_valid,
    input  logic               issue_writes,
    input  logic [RADDR_W-1:0] issue_rd,
    input  logic [RADDR_W-1:0] rs1_addr,
    input  logic [RADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0]  rs1_data,
    output logic [DATA_W-1:0]  rs2_data,
    output logic               rs1_busy,
    output logic               rs2_busy,
    output logic [15:0]        retire_count,
    output logic               sb_error
);

    logic [RADDR_W-1:0] wb_rd;
    logic               wb_en;
    logic               issue_en;
    logic [DATA_W-1:0]  rf_q [REG_COUNT];
    logic [15:0]        retire_q;
    logic [15:0]        retire_d;
    pend_t              rs1_pend;
    pend_t              rs2_pend;
    logic [DATA_W-1:0]  rs1_stored;
    logic [DATA_W-1:0]  rs2_stored;
    logic               unused_instr_bits;

    assign wb_rd             = memory_instr[RD_MSB:RD_LSB];
    assign unused_instr_bits = ^{memory_instr[15:RD_MSB+1], memory_instr[RD_LSB-1:0]};

    // Gating with reset_n keeps the bypass path quiet while reset is held.
    assign wb_en    = reset_n && memory_done && memory_is_dependent && (wb_rd != '0);
    assign issue_en = issue_valid && issue_writes && (issue_rd != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                rf_q[r] <= '0;
            end
        end else if (wb_en) begin
            rf_q[wb_rd] <= memory_result;
        end
    end

    assign retire_d = memory_done ? retire_q + 16'd1 : retire_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    wb_scoreboard #(
        .REG_COUNT(REG_COUNT)
    ) u_scoreboard (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .inc_en_i   (issue_en),
        .inc_rd_i   (issue_rd),
        .dec_en_i   (wb_en),
        .dec_rd_i   (wb_rd),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_pend_o (rs1_pend),
        .rs2_pend_o (rs2_pend),
        .sb_error_o (sb_error)
    );

    assign rs1_stored = (rs1_addr == '0) ? '0 : rf_q[rs1_addr];
    assign rs2_stored = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];

`ifdef WB_BYPASS_EN
    logic byp1;
    logic byp2;

    assign byp1     = wb_en && (wb_rd == rs1_addr);
    assign byp2     = wb_en && (wb_rd == rs2_addr);
    assign rs1_data = byp1 ? memory_result : rs1_stored;
    assign rs2_data = byp2 ? memory_result : rs2_stored;
    // The last outstanding write landing now clears the hazard this cycle.
    assign rs1_busy = (rs1_pend != '0) && !(byp1 && (rs1_pend == 2'd1));
    assign rs2_busy = (rs2_pend != '0) && !(byp2 && (rs2_pend == 2'd1));
`else
    assign rs1_data = rs1_stored;
    assign rs2_data = rs2_stored;
    assign rs1_busy = (rs1_pend != '0);
    assign rs2_busy = (rs2_pend != '0);
`endif

    assign retire_count = retire_q;

endmodule
